// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op encoding, op type and counter width shared by the logic unit
package logic_unit_pkg;
  typedef logic [2:0] op_t;
  localparam op_t LU_AND  = 3'b000;
  localparam op_t LU_OR   = 3'b001;
  localparam op_t LU_NAND = 3'b010;
  localparam op_t LU_NOR  = 3'b011;
  localparam op_t LU_XOR  = 3'b100;
  localparam op_t LU_XNOR = 3'b101;
  localparam op_t LU_ANDN = 3'b110;
  localparam op_t LU_PASS = 3'b111;
  localparam int CNT_W = 16;
endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core: combinational op decode, result and zero flag
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result,
  output logic             zero
);
  always_comb begin
    result = a;
    case (op)
      LU_AND:  result = a & b;
      LU_OR:   result = a | b;
      LU_NAND: result = ~(a & b);
      LU_NOR:  result = ~(a | b);
      LU_XOR:  result = a ^ b;
      LU_XNOR: result = ~(a ^ b);
      LU_ANDN: result = a & ~b;
      LU_PASS: result = a;
    endcase
  end
  assign zero = ~|result;
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise logic unit with saturating op counter
// Optional out_parity port and register under LOGIC_UNIT_PARITY_EN.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
`ifdef LOGIC_UNIT_PARITY_EN
  output logic             out_parity,
`endif
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] op_count
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic             s1_valid, s2_valid, s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_a, s1_b, res;
  op_t              s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic             zero;
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (res),
    .zero   (zero)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= LU_AND;
      s1_tag   <= '0;
      out_data <= '0;
      out_zero <= 1'b0;
      out_tag  <= '0;
      op_count <= '0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (in_valid && s1_adv) begin
        s1_a   <= A;
        s1_b   <= B;
        s1_op  <= op;
        s1_tag <= in_tag;
      end
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_valid && s2_adv) begin
        out_data <= res;
        out_zero <= zero;
        out_tag  <= s1_tag;
      end
      if (cnt_clr) op_count <= '0;
      else if (out_valid && out_ready && op_count != CNT_MAX) op_count <= op_count + 1'b1;
    end
  end
`ifdef LOGIC_UNIT_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out_parity <= 1'b0;
    else if (s1_valid && s2_adv) out_parity <= ^res;
  end
`endif
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed plus random checks of logic_unit_pipe against a truth-table scoreboard model
module tb_logic_unit_pipe;
  localparam int W = 16;
  localparam int T = 4;
  localparam logic [3:0] TT [8] = '{4'b1000, 4'b1110, 4'b0111, 4'b0001,
                                    4'b0110, 4'b1001, 4'b0100, 4'b1100};
  localparam logic [W-1:0] STREAM [8] = '{16'h000F, 16'h0FFF, 16'hFFF0, 16'hF000,
                                          16'h0FF0, 16'hF00F, 16'h00F0, 16'h00FF};
  logic clk = 0, reset = 0, in_valid = 0, out_ready = 0, cnt_clr = 0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic [T-1:0] in_tag = '0;
  logic in_ready, out_valid, out_zero;
  logic [W-1:0] out_data;
  logic [T-1:0] out_tag;
  logic [15:0] op_count;
`ifdef LOGIC_UNIT_PARITY_EN
  logic out_parity;
`endif
  typedef struct {logic [W-1:0] d; logic [T-1:0] t; int c;} ent_t;
  ent_t q[$];
  logic [W+T-1:0] seen[$];
  int seen_c[$];
  int cyc = 0, passed = 0, total = 0;
  logic [15:0] cnt = '0;

  logic_unit_pipe #(.WIDTH(W), .TAG_W(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_tag(out_tag),
`ifdef LOGIC_UNIT_PARITY_EN
    .out_parity(out_parity),
`endif
    .cnt_clr(cnt_clr), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] lu_ref(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [3:0] t;
    logic [W-1:0] r;
    t = TT[o];
    for (int i = 0; i < W; i++) r[i] = t[{x[i], y[i]}];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cycle(output bit acc);
    bit cmp, clr;
    ent_t e;
    #1;
    acc = in_valid && in_ready;
    cmp = out_valid && out_ready;
    clr = cnt_clr;
    e = '{lu_ref(op, a, b), in_tag, 0};
    chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
    if (cmp) begin
      chk("out_has_entry", q.size() > 0, 1);
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_tag", out_tag, q[0].t);
        chk("out_zero", out_zero, q[0].d == 0);
`ifdef LOGIC_UNIT_PARITY_EN
        chk("out_parity", out_parity, ^q[0].d);
`endif
      end
      seen.push_back({out_tag, out_data});
      seen_c.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    if (cmp && q.size() > 0) begin
      void'(q.pop_front());
      if (cnt != 16'hFFFF) cnt++;
    end
    if (clr) cnt = '0;
    if (acc) begin
      e.c = cyc;
      q.push_back(e);
    end
    #1;
    chk("op_count", op_count, cnt);
    chk("out_valid", out_valid, q.size() > 0 && q[0].c < cyc);
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o, input logic [T-1:0] t);
    bit ok;
    ok = 0;
    a = x; b = y; op = o; in_tag = t; in_valid = 1;
    for (int i = 0; i < 20 && !ok; i++) cycle(ok);
    in_valid = 0;
    chk("send_accepted", ok, 1);
  endtask

  initial begin
    bit acc;
    int n_acc;
    bit have;
    logic [W-1:0] hold;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_zero", out_zero, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef LOGIC_UNIT_PARITY_EN
    chk("rst_out_parity", out_parity, 0);
`endif
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    out_ready = 1;

    send(16'hF0F0, 16'hFF00, 3'b000, 4'h1);
    cycle(acc);
    chk("and_valid", out_valid, 1);
    chk("and_data", out_data, 16'hF000);
    chk("and_zero", out_zero, 0);
    cycle(acc);
    chk("and_count", op_count, 1);

    send(16'h1234, 16'h1234, 3'b100, 4'h5);
    cycle(acc);
    chk("xor_data", out_data, 16'h0000);
    chk("xor_zero", out_zero, 1);
    chk("xor_tag", out_tag, 4'h5);
    cycle(acc);
`ifdef LOGIC_UNIT_PARITY_EN
    send(16'h0000, 16'h0000, 3'b010, 4'h0);
    cycle(acc);
    chk("nand_data", out_data, 16'hFFFF);
    chk("nand_parity", out_parity, 0);
    cycle(acc);
`endif

    seen.delete(); seen_c.delete();
    for (int i = 0; i < 8; i++) begin
      a = 16'h00FF; b = 16'h0F0F; op = 3'(i); in_tag = 4'(i); in_valid = 1;
      cycle(acc);
      chk("stream_acc", acc, 1);
    end
    in_valid = 0;
    repeat (3) cycle(acc);
    chk("stream_len", seen.size(), 8);
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      chk("stream_data", seen[i], {4'(i), STREAM[i]});
      chk("stream_cycle", seen_c[i], seen_c[0] + i);
    end

    out_ready = 0; n_acc = 0; have = 0; hold = '0;
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom); b = W'($urandom); op = 3'($urandom); in_tag = T'($urandom); in_valid = 1;
      cycle(acc);
      if (acc) n_acc++;
      if (out_valid) begin
        if (have) chk("stall_stable", out_data, hold);
        hold = out_data; have = 1;
      end
    end
    chk("bp_accepted", n_acc, 2);
    chk("bp_in_ready_low", in_ready, 0);
    out_ready = 1;
    #1;
    chk("bp_in_ready_same_cycle", in_ready, 1);
    cycle(acc);
    chk("bp_drain_accept", acc, 1);
    in_valid = 0;
    repeat (4) cycle(acc);
    chk("bp_drained", out_valid, 0);

    for (int i = 0; i < 300; i++) begin
      a = W'($urandom); b = W'($urandom); op = 3'($urandom); in_tag = T'($urandom);
      in_valid = 1'($urandom); out_ready = 1'($urandom); cnt_clr = ($urandom_range(0, 49) == 0);
      cycle(acc);
    end
    cnt_clr = 0;

    out_ready = 1;
    for (int i = 0; i < 65540; i++) begin
      a = W'($urandom); b = W'($urandom); op = 3'($urandom); in_tag = T'($urandom); in_valid = 1;
      cycle(acc);
    end
    chk("sat_count", op_count, 16'hFFFF);
    chk("clr_handshake_pending", out_valid, 1);
    cnt_clr = 1;
    cycle(acc);
    cnt_clr = 0;
    chk("clr_priority", op_count, 0);

    out_ready = 0;
    repeat (3) cycle(acc);
    chk("full_before_reset", in_ready, 0);
    in_valid = 0;
    #2 reset = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_op_count", op_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_data", out_data, 0);
    q.delete(); cnt = '0;
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    cyc++;
    out_ready = 1;
    send(16'hA5A5, 16'h0FF0, 3'b110, 4'hC);
    cycle(acc);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 16'hA005);
    cycle(acc);
    chk("post_rst_count", op_count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
